data_sync_checker: RTL and testbench
====================================

# data_sync_checker

Single-clock stream checker at the read end of `data_fifo_sync`. It consumes the synchronized word stream and verifies it against an incrementing-count pattern (modulo 2^WIDTH) that a matching source drives on the write side. It acquires and loses pattern lock with hysteresis, and counts words, pattern mismatches and FIFO error events in saturating counters. It is used in bring-up builds and CDC regression benches to qualify the synchronizer.

## Interface
- `WIDTH`, 16: data word width.
- `LOCK_LEN`, 4: number of consecutive correct increments required to lock.
- `LOSS_LEN`, 3: number of consecutive mismatches while locked that drop the lock.
- `CNT_W`, 16: width of every statistics counter.

- `clk` in 1: read-domain clock; every register is clocked on the rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `enable` in 1: checker run; 0 forces IDLE.
- `clear` in 1: synchronous clear of all statistics counters.
- `valid` in 1: `data` is a new word this cycle.
- `data` in WIDTH: synchronized word (`sync` of `data_fifo_sync`).
- `fifo_error` in 1: `error` of `data_fifo_sync`.
- `locked` out 1: in LOCKED state.
- `mismatch` out 1: one-cycle pulse per mismatching word while locked.
- `expected` out WIDTH: next expected word; valid while locked.
- `word_cnt` out CNT_W: valid words accepted while LOCKED.
- `err_cnt` out CNT_W: mismatching words while LOCKED.
- `fifo_err_cnt` out CNT_W: rising edges of `fifo_error` seen while `enable` = 1.

## Operation
- FSM states: IDLE, SEARCH, LOCKED.
- Any state with `enable` = 0 goes to IDLE on the next edge. IDLE with `enable` = 1 goes to SEARCH.
- SEARCH, first valid word after entry: `ref` <= `data`, `run` <= 0.
- SEARCH, later valid words:
  - If `data` == `ref`+1 (mod 2^WIDTH): `run` <= `run`+1; otherwise `run` <= 0.
  - `ref` <= `data` on every valid word.
  - When the increment makes `run` == LOCK_LEN: go to LOCKED and load `expected` <= `data`+1.
- LOCKED, each valid word:
  - `word_cnt` +1.
  - `expected` <= `expected`+1. It is never reseeded from `data` while locked.
  - Match: `miss` <= 0.
  - Mismatch: `mismatch` pulses, `err_cnt` +1, `miss` +1.
  - When `miss` reaches LOSS_LEN: go to SEARCH and reseed as a first word (`ref` <= `data`, `run` <= 0).
- `valid` = 0: FSM, `ref`, `run`, `miss` and `expected` all hold.
- Wrap-around: the pattern and the compare use modulo-2^WIDTH arithmetic, so 0xFFFF → 0x0000 is a correct increment. Counter arithmetic is CNT_W bits wide.
- Counters saturate at all-ones and never wrap.
- `clear` zeroes all three counters. It has priority over a same-cycle increment, so the result is 0. It does not affect FSM state.
- `fifo_error` edge detection uses a registered copy of the previous value. Detection is independent of FSM state but gated by `enable`.

## Timing
- All outputs are registered. Response latency is 1 cycle after the edge that samples the input.
- `locked` rises the cycle after the valid word that completes LOCK_LEN increments. It falls the cycle after the LOSS_LEN-th consecutive mismatch, or after `enable` falls.
- `mismatch` is high for exactly one cycle per offending word. Back-to-back bad words give back-to-back pulses.
- Reset values:
  - State IDLE.
  - `locked` = 0, `mismatch` = 0, `expected` = 0.
  - All counters = 0.
  - `ref`, `run`, `miss` and the `fifo_error` history = 0.
- Reset asserted mid-operation clears everything immediately (asynchronously). After `resetn` rises, the block resumes from IDLE on the first edge.
- Minimum lock time from SEARCH entry is LOCK_LEN+1 valid words.

## Structure
- Package `data_sync_pkg` holds:
  - the state enum `sync_chk_state_t` (IDLE, SEARCH, LOCKED);
  - default constants for LOCK_LEN, LOSS_LEN and CNT_W.
- Sub-module `sat_counter` (parameter W; ports `clk`, `resetn`, `clr`, `inc`, `cnt`). It implements clear-priority saturating increment and is instantiated three times.
- FSM, compare logic and edge detector live in the top module.

## Test plan
- **Lock acquisition:** `enable` = 1, valid every cycle, data 0x0010, 0x0011, …, 0x0014. Required: `locked` = 1 one cycle after 0x0014, `expected` = 0x0015, `err_cnt` = 0.
- **Single error:** while locked, expected 0x0020 but 0xBEEF is sent, then 0x0021 onward. Required: one `mismatch` pulse, `err_cnt` = 1, `locked` stays 1.
- **Loss and reacquire:** while locked, three words 0x1234, 0x5555, 0x0000 all mismatch. Required: `locked` = 0 after the third. Then 0x0001 through 0x0004 with no further word: still unlocked (only 3 increments counted, `run` = 3 < LOCK_LEN), relock on 0x0005.
- **Wrap and gaps:** sequence 0xFFFD, 0xFFFE, 0xFFFF, 0x0000, 0x0001 with `valid` = 0 gaps between words. Required: lock on 0x0001, no mismatches.
- **Saturation and clear:** CNT_W = 4, 20 mismatching words while locked (LOSS_LEN large). Required: `err_cnt` = 15 and holds. `clear` asserted together with a mismatch → `err_cnt` = 0.
- **FIFO error and reset:** `fifo_error` held high for 5 cycles, then pulsed twice. Required: `fifo_err_cnt` = 3. Asserting `resetn` = 0 mid-stream → all outputs 0 immediately.

Source files
------------

// File: rtl/data_sync_pkg.sv
// Shared types and default constants for the synchronizer stream checker.
package data_sync_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    LOCKED = 2'd2
  } sync_chk_state_t;

  localparam int DEF_LOCK_LEN = 4;
  localparam int DEF_LOSS_LEN = 3;
  localparam int DEF_CNT_W    = 16;

endpackage

// File: rtl/sat_counter.sv
// Statistics counter: clear beats increment, and the count sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
    return (&v) ? v : v + W'(1);
  endfunction

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = sat_inc(cnt_q);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/data_sync_checker.sv
// Incrementing-pattern checker for the read side of data_fifo_sync: lock/loss
// hysteresis FSM, mismatch pulse, and saturating word/error/fifo-error counters.
module data_sync_checker
  import data_sync_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int LOCK_LEN = DEF_LOCK_LEN,
  parameter int LOSS_LEN = DEF_LOSS_LEN,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             enable,
  input  logic             clear,
  input  logic             valid,
  input  logic [WIDTH-1:0] data,
  input  logic             fifo_error,
  output logic             locked,
  output logic             mismatch,
  output logic [WIDTH-1:0] expected,
  output logic [CNT_W-1:0] word_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] fifo_err_cnt
);

  localparam int RUN_W  = $clog2(LOCK_LEN + 1);
  localparam int MISS_W = $clog2(LOSS_LEN + 1);
  localparam logic [RUN_W-1:0]  RUN_LOCK  = RUN_W'(LOCK_LEN);
  localparam logic [MISS_W-1:0] MISS_LOSS = MISS_W'(LOSS_LEN);

  sync_chk_state_t   state_q;
  logic              first_q;
  logic [WIDTH-1:0]  ref_q;
  logic [WIDTH-1:0]  expected_q;
  logic [RUN_W-1:0]  run_q;
  logic [MISS_W-1:0] miss_q;
  logic              locked_q;
  logic              mismatch_q;
  logic              fifo_err_prev_q;

  logic              word_ok;
  logic              word_inc;
  logic              err_inc;
  logic              fifo_err_inc;
  logic [RUN_W-1:0]  run_next;
  logic [MISS_W-1:0] miss_next;

  always_comb begin
    word_ok      = (data == expected_q);
    word_inc     = enable && valid && (state_q == LOCKED);
    err_inc      = word_inc && !word_ok;
    fifo_err_inc = enable && fifo_error && !fifo_err_prev_q;
    run_next     = run_q + RUN_W'(1);
    miss_next    = miss_q + MISS_W'(1);
  end

  // A loss arms first_q so the next valid word becomes the new reference,
  // which keeps relock at LOCK_LEN+1 words after every SEARCH entry.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q         <= IDLE;
      first_q         <= 1'b0;
      ref_q           <= '0;
      expected_q      <= '0;
      run_q           <= '0;
      miss_q          <= '0;
      locked_q        <= 1'b0;
      mismatch_q      <= 1'b0;
      fifo_err_prev_q <= 1'b0;
    end else begin
      mismatch_q      <= 1'b0;
      fifo_err_prev_q <= fifo_error;
      if (!enable) begin
        state_q  <= IDLE;
        locked_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            state_q <= SEARCH;
            first_q <= 1'b1;
          end
          SEARCH: begin
            if (valid) begin
              ref_q   <= data;
              first_q <= 1'b0;
              if (first_q) begin
                run_q <= '0;
              end else if (data == ref_q + WIDTH'(1)) begin
                run_q <= run_next;
                if (run_next == RUN_LOCK) begin
                  state_q    <= LOCKED;
                  locked_q   <= 1'b1;
                  expected_q <= data + WIDTH'(1);
                  miss_q     <= '0;
                end
              end else begin
                run_q <= '0;
              end
            end
          end
          LOCKED: begin
            if (valid) begin
              expected_q <= expected_q + WIDTH'(1);
              if (word_ok) begin
                miss_q <= '0;
              end else begin
                mismatch_q <= 1'b1;
                if (miss_next == MISS_LOSS) begin
                  state_q  <= SEARCH;
                  locked_q <= 1'b0;
                  ref_q    <= data;
                  run_q    <= '0;
                  miss_q   <= '0;
                  first_q  <= 1'b1;
                end else begin
                  miss_q <= miss_next;
                end
              end
            end
          end
          default: begin
            state_q  <= IDLE;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_word_cnt (
    .clk    (clk),
    .resetn (resetn),
    .clr    (clear),
    .inc    (word_inc),
    .cnt    (word_cnt)
  );

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk    (clk),
    .resetn (resetn),
    .clr    (clear),
    .inc    (err_inc),
    .cnt    (err_cnt)
  );

  sat_counter #(.W(CNT_W)) u_fifo_err_cnt (
    .clk    (clk),
    .resetn (resetn),
    .clr    (clear),
    .inc    (fifo_err_inc),
    .cnt    (fifo_err_cnt)
  );

  assign locked   = locked_q;
  assign mismatch = mismatch_q;
  assign expected = expected_q;

endmodule

// File: tb/tb_data_sync_checker.sv
// Directed bench for data_sync_checker: a reference model feeds a scoreboard per cycle,
// plus fixed-value checks of the lock/loss/wrap/saturation/fifo-error/reset behaviour.
module tb_data_sync_checker;

  logic        clk = 1'b0;
  logic        resetn;
  logic        enable;
  logic        clear;
  logic        valid;
  logic [15:0] data;
  logic        fifo_error;
  logic        locked;
  logic        mismatch;
  logic [15:0] expected;
  logic [15:0] word_cnt;
  logic [15:0] err_cnt;
  logic [15:0] fifo_err_cnt;

  logic        s_en;
  logic        s_clr;
  logic        s_vld;
  logic [15:0] s_data;
  logic        s_ferr;
  logic        s_locked;
  logic        s_mismatch;
  logic [15:0] s_expected;
  logic [3:0]  s_word_cnt;
  logic [3:0]  s_err_cnt;
  logic [3:0]  s_fifo_err_cnt;

  always #5 clk = ~clk;

  data_sync_checker dut (
    .clk          (clk),
    .resetn       (resetn),
    .enable       (enable),
    .clear        (clear),
    .valid        (valid),
    .data         (data),
    .fifo_error   (fifo_error),
    .locked       (locked),
    .mismatch     (mismatch),
    .expected     (expected),
    .word_cnt     (word_cnt),
    .err_cnt      (err_cnt),
    .fifo_err_cnt (fifo_err_cnt)
  );

  data_sync_checker #(.WIDTH(16), .LOCK_LEN(4), .LOSS_LEN(64), .CNT_W(4)) dut_s (
    .clk          (clk),
    .resetn       (resetn),
    .enable       (s_en),
    .clear        (s_clr),
    .valid        (s_vld),
    .data         (s_data),
    .fifo_error   (s_ferr),
    .locked       (s_locked),
    .mismatch     (s_mismatch),
    .expected     (s_expected),
    .word_cnt     (s_word_cnt),
    .err_cnt      (s_err_cnt),
    .fifo_err_cnt (s_fifo_err_cnt)
  );

  typedef struct packed {
    logic        locked;
    logic        mis;
    logic [15:0] expv;
    logic [15:0] wc;
    logic [15:0] ec;
    logic [15:0] fc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  int m_state, m_first, m_ref, m_run, m_miss, m_exp, m_wc, m_ec, m_fc;
  bit m_fprev, m_mis, m_locked;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_cmp++;
    assert (obs === req) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_first = 0; m_ref = 0; m_run = 0; m_miss = 0; m_exp = 0;
    m_wc = 0; m_ec = 0; m_fc = 0; m_fprev = 0; m_mis = 0; m_locked = 0;
  endtask

  function automatic int sat16(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  // Reference behaviour for the default-parameter instance (LOCK 4, LOSS 3, 16-bit counters).
  task automatic model_step();
    int nst;
    bit winc, einc, finc;
    nst = m_state; winc = 0; einc = 0; finc = 0;
    m_mis = 0;
    if (!enable) begin
      nst = 0;
    end else begin
      case (m_state)
        0: begin nst = 1; m_first = 1; end
        1: if (valid) begin
          if (m_first != 0) begin
            m_ref = int'(data); m_run = 0; m_first = 0;
          end else begin
            if (int'(data) == (m_ref + 1) % 65536) m_run++;
            else m_run = 0;
            m_ref = int'(data);
            if (m_run == 4) begin
              nst = 2; m_exp = (int'(data) + 1) % 65536; m_miss = 0;
            end
          end
        end
        default: if (valid) begin
          winc = 1;
          if (int'(data) == m_exp) begin
            m_miss = 0;
          end else begin
            m_mis = 1; einc = 1; m_miss++;
            if (m_miss == 3) begin
              nst = 1; m_ref = int'(data); m_run = 0; m_first = 1; m_miss = 0;
            end
          end
          m_exp = (m_exp + 1) % 65536;
        end
      endcase
    end
    if (enable && fifo_error && !m_fprev) finc = 1;
    m_fprev = fifo_error;
    if (clear) begin
      m_wc = 0; m_ec = 0; m_fc = 0;
    end else begin
      if (winc) m_wc = sat16(m_wc);
      if (einc) m_ec = sat16(m_ec);
      if (finc) m_fc = sat16(m_fc);
    end
    m_state  = nst;
    m_locked = (nst == 2);
  endtask

  task automatic cyc(input logic v, input logic [15:0] d);
    exp_t e;
    valid = v;
    data  = d;
    model_step();
    e.locked = m_locked;
    e.mis    = m_mis;
    e.expv   = 16'(m_exp);
    e.wc     = 16'(m_wc);
    e.ec     = 16'(m_ec);
    e.fc     = 16'(m_fc);
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("sb_locked", locked, e.locked);
    chk("sb_mismatch", mismatch, e.mis);
    chk("sb_expected", expected, e.expv);
    chk("sb_word_cnt", word_cnt, e.wc);
    chk("sb_err_cnt", err_cnt, e.ec);
    chk("sb_fifo_err_cnt", fifo_err_cnt, e.fc);
    @(negedge clk);
  endtask

  initial begin
    resetn = 1'b0; enable = 1'b0; clear = 1'b0; valid = 1'b0; data = '0; fifo_error = 1'b0;
    s_en = 1'b0; s_clr = 1'b0; s_vld = 1'b0; s_data = '0; s_ferr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_locked", locked, 0);
    chk("rst_mismatch", mismatch, 0);
    chk("rst_expected", expected, 0);
    chk("rst_counters", {word_cnt, err_cnt}, 0);
    chk("rst_fifo_err_cnt", fifo_err_cnt, 0);
    @(negedge clk);
    resetn = 1'b1;

    // Lock acquisition
    enable = 1'b1;
    cyc(1'b0, 16'h0000);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 16'h0010 + 16'(i));
      if (i == 3) chk("lock_early", locked, 0);
    end
    chk("lock_locked", locked, 1);
    chk("lock_expected", expected, 16'h0015);
    chk("lock_err_cnt", err_cnt, 0);

    // Single error
    for (int i = 0; i < 11; i++) cyc(1'b1, 16'h0015 + 16'(i));
    chk("single_pre_expected", expected, 16'h0020);
    cyc(1'b1, 16'hBEEF);
    chk("single_mismatch", mismatch, 1);
    chk("single_err_cnt", err_cnt, 1);
    chk("single_locked", locked, 1);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 16'h0021 + 16'(i));
      chk("single_no_pulse", mismatch, 0);
    end
    chk("single_word_cnt", word_cnt, 15);

    // Loss and reacquire
    cyc(1'b1, 16'h1234);
    chk("loss_hold1", locked, 1);
    cyc(1'b1, 16'h5555);
    chk("loss_b2b_pulse", mismatch, 1);
    cyc(1'b1, 16'h0000);
    chk("loss_unlocked", locked, 0);
    chk("loss_err_cnt", err_cnt, 4);
    for (int i = 1; i <= 4; i++) cyc(1'b1, 16'(i));
    chk("reacq_not_yet", locked, 0);
    cyc(1'b1, 16'h0005);
    chk("reacq_locked", locked, 1);
    chk("reacq_expected", expected, 16'h0006);

    // Enable drop, then wrap with gaps
    enable = 1'b0;
    cyc(1'b0, 16'h0000);
    chk("disable_unlock", locked, 0);
    enable = 1'b1;
    cyc(1'b0, 16'h0000);
    cyc(1'b1, 16'hFFFD); cyc(1'b0, 16'h1111);
    cyc(1'b1, 16'hFFFE); cyc(1'b0, 16'h2222);
    cyc(1'b1, 16'hFFFF); cyc(1'b0, 16'h3333);
    cyc(1'b1, 16'h0000); cyc(1'b0, 16'h4444);
    chk("wrap_not_yet", locked, 0);
    cyc(1'b1, 16'h0001);
    chk("wrap_locked", locked, 1);
    chk("wrap_expected", expected, 16'h0002);
    chk("wrap_err_cnt", err_cnt, 4);

    // FIFO error edges and clear
    fifo_error = 1'b1;
    repeat (5) cyc(1'b0, 16'h0000);
    fifo_error = 1'b0; cyc(1'b0, 16'h0000);
    fifo_error = 1'b1; cyc(1'b0, 16'h0000);
    fifo_error = 1'b0; cyc(1'b0, 16'h0000);
    fifo_error = 1'b1; cyc(1'b0, 16'h0000);
    fifo_error = 1'b0; cyc(1'b0, 16'h0000);
    chk("fifo_err_cnt", fifo_err_cnt, 3);
    clear = 1'b1; cyc(1'b0, 16'h0000); clear = 1'b0;
    chk("clear_fifo_err_cnt", fifo_err_cnt, 0);
    chk("clear_keeps_lock", locked, 1);

    // Saturation on the 4-bit instance with a long loss threshold
    s_en = 1'b1; s_vld = 1'b0;
    cyc(1'b0, 16'h0000);
    s_vld = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s_data = 16'(i);
      cyc(1'b0, 16'h0000);
    end
    chk("sat_locked", s_locked, 1);
    chk("sat_expected", s_expected, 16'h0005);
    s_data = 16'hAAAA;
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, 16'h0000);
      if (i < 2) chk("sat_b2b_pulse", s_mismatch, 1);
    end
    chk("sat_err_cnt", s_err_cnt, 15);
    chk("sat_word_cnt", s_word_cnt, 15);
    chk("sat_still_locked", s_locked, 1);
    cyc(1'b0, 16'h0000);
    chk("sat_err_hold", s_err_cnt, 15);
    s_clr = 1'b1;
    cyc(1'b0, 16'h0000);
    s_clr = 1'b0; s_vld = 1'b0;
    chk("sat_clear_err", s_err_cnt, 0);
    chk("sat_clear_word", s_word_cnt, 0);
    chk("sat_clear_pulse", s_mismatch, 1);

    // Asynchronous reset mid-stream
    valid = 1'b1; data = 16'h0002;
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_locked", locked, 0);
    chk("arst_expected", expected, 0);
    chk("arst_counters", {word_cnt, err_cnt, fifo_err_cnt}, 0);
    chk("arst_s_locked", s_locked, 0);
    chk("arst_s_expected", s_expected, 0);
    model_reset();
    @(negedge clk);
    resetn = 1'b1;
    cyc(1'b0, 16'h0000);
    chk("post_rst_unlocked", locked, 0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 16'h0100 + 16'(i));
    chk("post_rst_relock", locked, 1);
    chk("post_rst_expected", expected, 16'h0105);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
